// File: rtl/axi4full_master_bridge.sv
// axi4full_master_bridge
//   Turns a simple one-request-at-a-time valid/ready request interface into
//   AXI4 transactions. Reads are INCR bursts of (len+1) 8-byte beats. Writes
//   are single 8-byte beats. Every R beat, and the single B response, is passed
//   straight through to the response port.
// Ports
//   i_aclk / i_arsetn        clock, asynchronous active-low reset
//   i_req_* / o_req_ready    request: wen, addr, len (reads), wdata, wstrb
//   o_rsp_* / i_rsp_ready    response beats: rdata, last, err
//   o_aw*/o_w*/i_b*          AXI write address / data / response channels
//   o_ar*/i_r*               AXI read address / data channels
//   id/lock/cache/prot       tied to zero; i_bid and i_rid are ignored
module axi4full_master_bridge #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_aclk,
  input  logic                  i_arsetn,
  // request / response
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [7:0]            i_req_len,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [STRB_WIDTH-1:0] i_req_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_last,
  output logic                  o_rsp_err,
  // AXI write address
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_WIDTH-1:0] o_wstrb,
  output logic                  o_wlast,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  // AXI write response
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  input  logic [3:0]            i_bid,
  output logic                  o_bready,
  // AXI read address
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  // AXI read data
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  input  logic [3:0]            i_rid,
  output logic                  o_rready,
  // unused AXI sideband, tied off
  output logic [3:0]            o_awid,
  output logic [3:0]            o_arid,
  output logic [3:0]            o_wid,
  output logic [1:0]            o_awlock,
  output logic [1:0]            o_arlock,
  output logic [3:0]            o_awcache,
  output logic [3:0]            o_arcache,
  output logic [2:0]            o_awprot,
  output logic [2:0]            o_arprot
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

  state_t                state, state_nxt;
  logic                  cap_wen;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [7:0]            cap_len;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_WIDTH-1:0] cap_wstrb;
  logic [7:0]            beat_cnt;
  logic                  aw_done, w_done;

  logic req_fire, ar_fire, r_fire, aw_fire, w_fire, b_fire, r_final;

  assign req_fire = i_req_valid & o_req_ready;
  assign ar_fire  = o_arvalid & i_arready;
  assign r_fire   = i_rvalid & o_rready;
  assign aw_fire  = o_awvalid & i_awready;
  assign w_fire   = o_wvalid & i_wready;
  assign b_fire   = i_bvalid & o_bready;
  // The burst ends on our own beat count; a wrong i_rlast is only flagged.
  assign r_final  = (beat_cnt == cap_len);

  // ---- state register
  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // ---- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_req_valid) state_nxt = i_req_wen ? S_WR : S_AR;
      S_AR:   if (ar_fire) state_nxt = S_R;
      S_R:    if (r_fire && r_final) state_nxt = S_IDLE;
      // AW and W may complete in either order or together
      S_WR:   if ((aw_done | aw_fire) && (w_done | w_fire)) state_nxt = S_B;
      S_B:    if (b_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- outputs
  always_comb begin
    o_req_ready = 1'b0;
    o_arvalid   = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_rready    = 1'b0;
    o_bready    = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = '0;
    o_rsp_last  = 1'b0;
    o_rsp_err   = 1'b0;
    case (state)
      S_IDLE: o_req_ready = 1'b1;
      S_AR:   o_arvalid   = 1'b1;
      S_R: begin
        o_rready    = i_rsp_ready;
        o_rsp_valid = i_rvalid;
        o_rsp_rdata = i_rdata;
        o_rsp_last  = r_final;
        o_rsp_err   = i_rresp[1] | (i_rlast != r_final);
      end
      S_WR: begin
        o_awvalid = ~aw_done;
        o_wvalid  = ~w_done;
      end
      S_B: begin
        o_bready    = i_rsp_ready;
        o_rsp_valid = i_bvalid;
        o_rsp_last  = 1'b1;
        o_rsp_err   = i_bresp[1];
      end
      default: ;
    endcase
  end

  // ---- captured request, beat counter, AW/W completion flags
  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) begin
      cap_wen   <= 1'b0;
      cap_addr  <= '0;
      cap_len   <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      beat_cnt  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else if (req_fire) begin
      cap_wen   <= i_req_wen;
      cap_addr  <= i_req_addr;
      cap_len   <= i_req_len;
      cap_wdata <= i_req_wdata;
      cap_wstrb <= i_req_wstrb;
      beat_cnt  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      if (r_fire)  beat_cnt <= beat_cnt + 8'd1;
      if (aw_fire) aw_done  <= 1'b1;
      if (w_fire)  w_done   <= 1'b1;
    end
  end

  // Payloads come straight from the capture registers, so they are stable
  // while the matching valid waits for its ready.
  assign o_araddr  = cap_addr;
  assign o_arlen   = cap_len;
  assign o_arsize  = 3'd3;
  assign o_arburst = 2'b01;
  assign o_awaddr  = cap_addr;
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;
  assign o_wdata   = cap_wdata;
  assign o_wstrb   = cap_wstrb;
  assign o_wlast   = 1'b1;

  assign o_awid    = '0;
  assign o_arid    = '0;
  assign o_wid     = '0;
  assign o_awlock  = '0;
  assign o_arlock  = '0;
  assign o_awcache = '0;
  assign o_arcache = '0;
  assign o_awprot  = '0;
  assign o_arprot  = '0;

  logic unused_ok;
  assign unused_ok = ^{i_bid, i_rid, i_bresp[0], i_rresp[0], cap_wen};

endmodule

// File: tb/tb_axi4full_master_bridge.sv
// Bench for axi4full_master_bridge: directed vector table, a reset-mid-burst
// sequence and randomized transactions against a transaction-level model.
module tb_axi4full_master_bridge;

  logic        i_aclk = 1'b0;
  logic        i_arsetn;
  logic        i_req_valid, i_req_wen;
  logic [31:0] i_req_addr;
  logic [7:0]  i_req_len;
  logic [63:0] i_req_wdata;
  logic [7:0]  i_req_wstrb;
  logic        o_req_ready, o_rsp_valid, i_rsp_ready, o_rsp_last, o_rsp_err;
  logic [63:0] o_rsp_rdata;
  logic [31:0] o_awaddr, o_araddr;
  logic [7:0]  o_awlen, o_arlen;
  logic [2:0]  o_awsize, o_arsize;
  logic [1:0]  o_awburst, o_arburst;
  logic        o_awvalid, i_awready, o_wlast, o_wvalid, i_wready;
  logic [63:0] o_wdata, i_rdata;
  logic [7:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;
  logic        i_bvalid, o_bready, o_arvalid, i_arready;
  logic        i_rlast, i_rvalid, o_rready;
  logic [3:0]  i_bid, i_rid;
  logic [3:0]  o_awid, o_arid, o_wid, o_awcache, o_arcache;
  logic [1:0]  o_awlock, o_arlock;
  logic [2:0]  o_awprot, o_arprot;

  axi4full_master_bridge dut (
    .i_aclk(i_aclk), .i_arsetn(i_arsetn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len), .i_req_wdata(i_req_wdata),
    .i_req_wstrb(i_req_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_last(o_rsp_last), .o_rsp_err(o_rsp_err),
    .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .i_bid(i_bid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .i_rid(i_rid), .o_rready(o_rready),
    .o_awid(o_awid), .o_arid(o_arid), .o_wid(o_wid), .o_awlock(o_awlock),
    .o_arlock(o_arlock), .o_awcache(o_awcache), .o_arcache(o_arcache),
    .o_awprot(o_awprot), .o_arprot(o_arprot)
  );

  always #5 i_aclk = ~i_aclk;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  resp;       // bresp for writes, rresp of every beat for reads
    logic [7:0]  rlast_mask; // which read beats the slave flags with rlast
    logic [63:0] base;       // read beat i carries base ^ i
    int          aw_dly;     // first cycle (1 = right after request) arready/awready high
    int          w_dly;      // first cycle wready high
    bit          tog;        // response consumer ready only on odd cycles
    int          exp_beats;
    logic [7:0]  exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        err;
  } beat_t;

  vec_t        vt[9];
  beat_t       exp_q[$];
  logic [63:0] rd_data[256];
  logic [1:0]  rd_resp[256];
  logic        rd_last[256];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One whole transaction: drives the request, plays an AXI slave (valids held
  // until accepted), consumes response beats and compares them to exp_q.
  task automatic run_txn(input bit wen, input logic [31:0] addr, input logic [7:0] len,
                         input logic [63:0] wdata, input logic [7:0] wstrb,
                         input logic [1:0] bresp, input bit rnd, input int aw_dly,
                         input int w_dly, input bit tog);
    int cyc = 1, got = 0, ar_n = 0, aw_n = 0, w_n = 0, rbeat = 0;
    bit ar_ok = 0, aw_ok = 0, w_ok = 0, b_ok = 0, rv = 0, bv = 0, done = 0;
    bit p_ar = 0, p_aw = 0, p_w = 0;
    logic [31:0] p_araddr = '0, p_awaddr = '0;
    logic [63:0] p_wdata = '0;
    @(negedge i_aclk);
    i_req_valid = 1'b1; i_req_wen = wen; i_req_addr = addr; i_req_len = len;
    i_req_wdata = wdata; i_req_wstrb = wstrb;
    #1 chk("req_ready_idle", o_req_ready, 1);
    @(negedge i_aclk);
    // scramble request inputs: the DUT must work from its captured copy
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_len = 8'($urandom);
    i_req_wdata = {$urandom, $urandom}; i_req_wstrb = 8'($urandom); i_req_wen = ~wen;
    while (!done && cyc < 400) begin
      if (rnd) begin
        i_arready = 1'($urandom_range(0, 1));
        i_awready = 1'($urandom_range(0, 1));
        i_wready  = 1'($urandom_range(0, 1));
        i_rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_arready = (cyc >= aw_dly);
        i_awready = (cyc >= aw_dly);
        i_wready  = (cyc >= w_dly);
        i_rsp_ready = tog ? (cyc % 2 == 1) : 1'b1;
      end
      if (!rv && ar_ok && rbeat <= int'(len)) rv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_rvalid = rv;
      i_rdata  = rv ? rd_data[rbeat] : 64'h0;
      i_rresp  = rv ? rd_resp[rbeat] : 2'b00;
      i_rlast  = rv ? rd_last[rbeat] : 1'b0;
      if (!bv && aw_ok && w_ok && !b_ok) bv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_bvalid = bv;
      i_bresp  = bresp;
      #1;
      if (o_req_ready) done = 1;
      else begin
        if (p_ar) begin chk("ar_hold", o_arvalid, 1); chk("ar_hold_addr", o_araddr, p_araddr); end
        if (p_aw) begin chk("aw_hold", o_awvalid, 1); chk("aw_hold_addr", o_awaddr, p_awaddr); end
        if (p_w)  begin chk("w_hold", o_wvalid, 1);   chk("w_hold_data", o_wdata, p_wdata);    end
        if (o_arvalid && i_arready) begin
          ar_n++; ar_ok = 1;
          chk("araddr", o_araddr, addr); chk("arlen", o_arlen, len);
          chk("arsize", o_arsize, 3);    chk("arburst", o_arburst, 1);
        end
        if (o_awvalid && i_awready) begin
          aw_n++; aw_ok = 1;
          chk("awaddr", o_awaddr, addr); chk("awlen", o_awlen, 0);
          chk("awsize", o_awsize, 3);    chk("awburst", o_awburst, 1);
        end
        if (o_wvalid && i_wready) begin
          w_n++; w_ok = 1;
          chk("wdata", o_wdata, wdata); chk("wstrb", o_wstrb, wstrb); chk("wlast", o_wlast, 1);
        end
        if (o_rsp_valid && i_rsp_ready) begin
          if (got < exp_q.size()) begin
            chk("rsp_data", o_rsp_rdata, exp_q[got].data);
            chk("rsp_last", o_rsp_last, exp_q[got].last);
            chk("rsp_err", o_rsp_err, exp_q[got].err);
          end else chk("rsp_extra_beat", got, exp_q.size() - 1);
          got++;
        end
        if (rv && o_rready) begin rbeat++; rv = 0; end
        if (bv && o_bready) begin b_ok = 1; bv = 0; end
        p_ar = o_arvalid && !i_arready; p_araddr = o_araddr;
        p_aw = o_awvalid && !i_awready; p_awaddr = o_awaddr;
        p_w  = o_wvalid && !i_wready;   p_wdata = o_wdata;
        @(negedge i_aclk);
        cyc++;
      end
    end
    if (!done) chk("txn_timeout", cyc, 0);
    chk("beat_count", got, exp_q.size());
    chk("ar_fires", ar_n, wen ? 0 : 1);
    chk("aw_fires", aw_n, wen ? 1 : 0);
    chk("w_fires", w_n, wen ? 1 : 0);
    i_rvalid = 0; i_bvalid = 0; i_arready = 0; i_awready = 0; i_wready = 0; i_rsp_ready = 0;
  endtask

  task automatic run_vec(input int k);
    beat_t b;
    exp_q.delete();
    for (int i = 0; i <= int'(vt[k].len); i++) begin
      rd_data[i] = vt[k].base ^ 64'(i);
      rd_resp[i] = vt[k].resp;
      rd_last[i] = vt[k].rlast_mask[i];
    end
    for (int i = 0; i < vt[k].exp_beats; i++) begin
      b.data = vt[k].wen ? 64'h0 : (vt[k].base ^ 64'(i));
      b.last = (i == vt[k].exp_beats - 1);
      b.err  = vt[k].exp_err[i];
      exp_q.push_back(b);
    end
    run_txn(vt[k].wen, vt[k].addr, vt[k].len, vt[k].wdata, vt[k].wstrb, vt[k].resp,
            1'b0, vt[k].aw_dly, vt[k].w_dly, vt[k].tog);
  endtask

  initial begin
    beat_t b;
    bit wen;
    logic [7:0] len;
    logic [1:0] bresp;
    logic [31:0] addr;
    logic [63:0] wdata;

    //         wen addr          len  wdata          wstrb  resp   rlast  base                    aw w tog beats err
    vt[0] = '{0, 32'h8000_0000, 8'd0, 64'h0,          8'h00, 2'b00, 8'h01, 64'h1122334455667788, 1, 1, 0, 1, 8'h00};
    vt[1] = '{0, 32'h8000_0100, 8'd3, 64'h0,          8'h00, 2'b00, 8'h08, 64'ha5a5_0000_5a5a_0000, 1, 1, 1, 4, 8'h00};
    vt[2] = '{1, 32'h8000_0010, 8'd0, 64'hdeadbeef,   8'h0f, 2'b00, 8'h00, 64'h0,                2, 4, 0, 1, 8'h00};
    vt[3] = '{0, 32'h8000_0020, 8'd0, 64'h0,          8'h00, 2'b10, 8'h01, 64'h0bad_0bad_0bad_0000, 1, 1, 0, 1, 8'h01};
    vt[4] = '{0, 32'h8000_0028, 8'd1, 64'h0,          8'h00, 2'b00, 8'h03, 64'h7777_0000_0000_0010, 1, 1, 0, 2, 8'h01};
    vt[5] = '{1, 32'h8000_0030, 8'd0, 64'h0123_4567_89ab_cdef, 8'hff, 2'b10, 8'h00, 64'h0, 3, 1, 0, 1, 8'h01};
    vt[6] = '{1, 32'h8000_0038, 8'd0, 64'hcafe_f00d_0000_1111, 8'hf0, 2'b01, 8'h00, 64'h0, 2, 2, 1, 1, 8'h00};
    vt[7] = '{0, 32'h8000_0040, 8'd2, 64'h0,          8'h00, 2'b01, 8'h04, 64'h3333_4444_5555_6600, 3, 1, 0, 3, 8'h00};
    vt[8] = '{0, 32'h8000_0048, 8'd1, 64'h0,          8'h00, 2'b00, 8'h00, 64'h9999_0000_0000_0020, 1, 1, 0, 2, 8'h02};

    i_arsetn = 0; i_req_valid = 0; i_req_wen = 0; i_req_addr = 0; i_req_len = 0;
    i_req_wdata = 0; i_req_wstrb = 0; i_rsp_ready = 0; i_awready = 0; i_wready = 0;
    i_bresp = 0; i_bvalid = 0; i_bid = 4'h5; i_arready = 0; i_rdata = 0; i_rresp = 0;
    i_rlast = 0; i_rvalid = 0; i_rid = 4'ha;
    #1;
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_valids", {o_arvalid, o_awvalid, o_wvalid, o_rsp_valid, o_rready, o_bready}, 0);
    chk("rst_tieoffs", {o_awid, o_arid, o_wid, o_awlock, o_arlock, o_awcache, o_arcache,
                        o_awprot, o_arprot}, 0);
    @(negedge i_aclk); @(negedge i_aclk);
    i_arsetn = 1;

    for (int k = 0; k < 9; k++) run_vec(k);

    // reset in the middle of a 4-beat read, after one beat was delivered
    @(negedge i_aclk);
    i_req_valid = 1; i_req_wen = 0; i_req_addr = 32'h8000_0200; i_req_len = 8'd3;
    @(negedge i_aclk);
    i_req_valid = 0; i_arready = 1;
    #1 chk("mid_rst_arvalid", o_arvalid, 1);
    @(negedge i_aclk);
    i_arready = 0; i_rvalid = 1; i_rdata = 64'h1; i_rlast = 0; i_rresp = 0; i_rsp_ready = 1;
    #1 chk("mid_rst_beat0", {o_rsp_valid, o_rsp_last, o_rsp_rdata[7:0]}, {1'b1, 1'b0, 8'h01});
    @(negedge i_aclk);
    i_rdata = 64'h2;
    #1 chk("mid_rst_beat1_valid", o_rsp_valid, 1);
    #2 i_arsetn = 0;
    #1 chk("async_rst_rsp_valid", o_rsp_valid, 0);
    chk("async_rst_rready", o_rready, 0);
    chk("async_rst_req_ready", o_req_ready, 1);
    chk("async_rst_araddr", o_araddr, 0);
    @(negedge i_aclk);
    i_rvalid = 0; i_rsp_ready = 0; i_rdata = 0;
    i_arsetn = 1;
    run_vec(0);

    // randomized transactions; expectations from the transaction rules
    for (int n = 0; n < 40; n++) begin
      wen   = 1'($urandom_range(0, 1));
      len   = 8'($urandom_range(0, 7));
      addr  = $urandom & 32'hffff_fff8;
      wdata = {$urandom, $urandom};
      bresp = 2'($urandom_range(0, 3));
      exp_q.delete();
      if (wen) begin
        b.data = 64'h0; b.last = 1'b1; b.err = bresp[1];
        exp_q.push_back(b);
      end else begin
        for (int i = 0; i <= int'(len); i++) begin
          rd_data[i] = {$urandom, $urandom};
          rd_resp[i] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
          rd_last[i] = ($urandom_range(0, 9) == 0) ? (i != int'(len)) : (i == int'(len));
          b.data = rd_data[i];
          b.last = (i == int'(len));
          b.err  = rd_resp[i][1] | (rd_last[i] != (i == int'(len)));
          exp_q.push_back(b);
        end
      end
      run_txn(wen, addr, len, wdata, 8'($urandom), bresp, 1'b1, 0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
